cellrv32_npu_instruction_window: RTL and testbench

Parametrised, handshaked look-ahead window between the NPU instruction FIFO and the control coordinator. It holds up to DEPTH instructions in order. A weight-load instruction at the head is not issued until a successor instruction is present, so weight loads always pair with the following matrix-multiply. It adds a drain control, a flush control, occupancy status and an optional stall timeout.

---
 rtl/cellrv32_npu_package.sv | 18 +
 rtl/cellrv32_npu_inst_ring.sv | 65 ++++++
 rtl/cellrv32_npu_instruction_window.sv | 107 ++++++++++
 tb/tb_cellrv32_npu_instruction_window.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cellrv32_npu_package.sv
// Shared NPU types: instruction format and weight-load opcode classification.
package cellrv32_npu_package;

    localparam int OP_CODE_WIDTH = 8;
    localparam int OPERAND_WIDTH = 24;

    typedef struct packed {
        logic [OP_CODE_WIDTH-1:0] opcode;
        logic [OPERAND_WIDTH-1:0] operand;
    } instruction_t;

    localparam logic [4:0] WEIGHT_OPCODE_PREFIX = 5'b00001;

    function automatic logic is_weight_inst(input instruction_t inst);
        return inst.opcode[OP_CODE_WIDTH-1:3] == WEIGHT_OPCODE_PREFIX;
    endfunction

endpackage

// File: rtl/cellrv32_npu_inst_ring.sv
// DEPTH-entry in-order circular buffer with push/pop/flush and head read.
module cellrv32_npu_inst_ring
    import cellrv32_npu_package::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  instruction_t  data_i,
    output instruction_t  head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    instruction_t  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            wp_d = (wp_q == LAST) ? '0 : wp_q + PW'(1);
        end
        if (pop_i) begin
            rp_d = (rp_q == LAST) ? '0 : rp_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !rst_i) begin
            mem_q[wp_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/cellrv32_npu_instruction_window.sv
// Look-ahead window pairing weight loads with their successor instruction.
// Optional held-weight timeout: define CELLRV32_NPU_LOOK_AHEAD_TIMEOUT_EN.
module cellrv32_npu_instruction_window
    import cellrv32_npu_package::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         flush_i,
    input  logic                         drain_i,
    input  instruction_t                 inst_i,
    input  logic                         inst_valid_i,
    output logic                         inst_ready_o,
    output instruction_t                 inst_o,
    output logic                         inst_valid_o,
    input  logic                         inst_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         weight_wait_o,
    output logic                         timeout_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] count;
    instruction_t  head;
    logic          push, pop, active;
    logic          head_w, has1, has2;
    logic          expired, rel;

    cellrv32_npu_inst_ring #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_ring (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (inst_i),
        .head_o  (head),
        .count_o (count)
    );

    assign active       = enable_i & ~flush_i & ~rst_i;
    assign inst_ready_o = enable_i & ~flush_i & (count < DEPTH_C);
    assign push         = inst_valid_i & inst_ready_o;

    assign has1   = (count != '0);
    assign has2   = (count > CW'(1));
    assign head_w = is_weight_inst(head);

    // A lone weight waits for its matmul partner unless drained or timed out.
    assign rel = has1 & (~head_w | has2 | drain_i | expired);

    assign inst_valid_o  = active & rel;
    assign pop           = inst_valid_o & inst_ready_i;
    assign inst_o        = inst_valid_o ? head : '0;
    assign weight_wait_o = enable_i & ~rst_i & has1 & head_w & ~rel;
    assign count_o       = count;

`ifdef CELLRV32_NPU_LOOK_AHEAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          fired_q, fired_d;

    assign expired   = (tcnt_q == TMAX);
    assign timeout_o = inst_valid_o & head_w & ~has2 & ~drain_i
                     & expired & ~fired_q;

    always_comb begin
        tcnt_d  = tcnt_q;
        fired_d = fired_q;
        if (pop) begin
            tcnt_d  = '0;
            fired_d = 1'b0;
        end else begin
            if (weight_wait_o && tcnt_q != TMAX) begin
                tcnt_d = tcnt_q + TW'(1);
            end
            if (timeout_o) begin
                fired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            tcnt_q  <= '0;
            fired_q <= 1'b0;
        end else if (enable_i) begin
            tcnt_q  <= tcnt_d;
            fired_q <= fired_d;
        end
    end
`else
    // Without the timer a held weight never expires; a zero timeout is illegal.
    assign expired   = (TIMEOUT_CYCLES < 1);
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cellrv32_npu_instruction_window.sv
// Scoreboard bench for the NPU look-ahead instruction window (DEPTH=4).
module tb_cellrv32_npu_instruction_window;
    import cellrv32_npu_package::*;

    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic         clk = 1'b0;
    logic         rst_i, enable_i, flush_i, drain_i;
    instruction_t inst_i, inst_o;
    logic         inst_valid_i, inst_ready_o, inst_valid_o, inst_ready_i;
    logic [2:0]   count_o;
    logic         weight_wait_o, timeout_o;

    int checks   = 0;
    int failures = 0;

    instruction_t sb[$];

    cellrv32_npu_instruction_window #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .flush_i       (flush_i),
        .drain_i       (drain_i),
        .inst_i        (inst_i),
        .inst_valid_i  (inst_valid_i),
        .inst_ready_o  (inst_ready_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .count_o       (count_o),
        .weight_wait_o (weight_wait_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst_i && inst_valid_o && inst_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", inst_o, 32'h0);
                if (inst_o == '0) begin
                    failures++;
                    $display("FAIL unexpected_issue actual=valid required=idle");
                end
            end else begin
                chk("issue_order", inst_o, sb.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        inst_i       = instruction_t'(v);
        inst_valid_i = 1'b1;
        step(1);
        inst_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int rel_at;
        rst_i = 1; enable_i = 1; flush_i = 0; drain_i = 0;
        inst_i = '0; inst_valid_i = 0; inst_ready_i = 0;
        step(2);
        @(negedge clk);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_wwait", weight_wait_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_ready", inst_ready_o, 1);
        step(1);
        rst_i = 0;

        // Non-weight issues one cycle after push.
        inst_ready_i = 1;
        sb.push_back(instruction_t'(32'h10_000001));
        push(32'h10_000001);
        @(negedge clk);
        chk("nw_valid", inst_valid_o, 1);
        chk("nw_count", count_o, 1);
        step(1);
        @(negedge clk);
        chk("nw_count_after", count_o, 0);

        // Lone weight is held, then paired with matmul.
        step(1);
        push(32'h08_000002);
        step(3);
        @(negedge clk);
        chk("w_held_valid", inst_valid_o, 0);
        chk("w_held_wwait", weight_wait_o, 1);
        chk("w_held_count", count_o, 1);
        sb.push_back(instruction_t'(32'h08_000002));
        sb.push_back(instruction_t'(32'h20_000003));
        step(1);
        push(32'h20_000003);
        @(negedge clk);
        chk("w_pair_valid", inst_valid_o, 1);
        chk("w_pair_head", inst_o, 32'h08_000002);
        step(3);
        @(negedge clk);
        chk("w_pair_count", count_o, 0);

        // Fill to full with the consumer stalled, then drain across wrap.
        inst_ready_i = 0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            inst_i       = instruction_t'(32'h11_000100 + i);
            inst_valid_i = 1'b1;
            @(negedge clk);
            chk("fill_ready", inst_ready_o, (i < DEPTH) ? 1 : 0);
            if (i < DEPTH) sb.push_back(inst_i);
            step(1);
        end
        inst_valid_i = 0;
        @(negedge clk);
        chk("full_count", count_o, DEPTH);
        chk("full_ready", inst_ready_o, 0);
        chk("stall_head", inst_o, 32'h11_000100);
        step(1);
        inst_ready_i = 1;
        step(5);
        @(negedge clk);
        chk("wrap_count", count_o, 0);

        // Drain releases a lone weight in the same cycle.
        step(1);
        push(32'h0F_000010);
        step(1);
        @(negedge clk);
        chk("drain_pre_wwait", weight_wait_o, 1);
        chk("drain_pre_valid", inst_valid_o, 0);
        step(1);
        sb.push_back(instruction_t'(32'h0F_000010));
        drain_i = 1;
        @(negedge clk);
        chk("drain_valid", inst_valid_o, 1);
        chk("drain_wwait", weight_wait_o, 0);
        chk("drain_count", count_o, 1);
        step(1);
        drain_i = 0;
        @(negedge clk);
        chk("drain_count_after", count_o, 0);

        // Flush drops contents and the concurrent push.
        step(1);
        inst_ready_i = 0;
        push(32'h12_000001);
        push(32'h12_000002);
        push(32'h12_000003);
        @(negedge clk);
        chk("preflush_count", count_o, 3);
        step(1);
        flush_i = 1;
        inst_i = instruction_t'(32'h12_000004);
        inst_valid_i = 1;
        @(negedge clk);
        chk("flush_ready", inst_ready_o, 0);
        chk("flush_valid", inst_valid_o, 0);
        step(1);
        flush_i = 0;
        inst_valid_i = 0;
        @(negedge clk);
        chk("postflush_count", count_o, 0);
        chk("postflush_valid", inst_valid_o, 0);
        chk("postflush_inst", inst_o, 0);
        step(1);
        inst_ready_i = 1;
        step(3);

        // Disabled window accepts nothing.
        enable_i = 0;
        inst_i = instruction_t'(32'h13_000001);
        inst_valid_i = 1;
        @(negedge clk);
        chk("dis_ready", inst_ready_o, 0);
        step(1);
        inst_valid_i = 0;
        enable_i = 1;
        @(negedge clk);
        chk("dis_count", count_o, 0);
        step(1);

`ifdef CELLRV32_NPU_LOOK_AHEAD_TIMEOUT_EN
        // Held weight released by timeout; disabled cycles extend the wait.
        sb.push_back(instruction_t'(32'h08_000077));
        push(32'h08_000077);
        waits  = 0;
        rel_at = -1;
        for (int i = 0; i < 40; i++) begin
            enable_i = !(i >= 3 && i <= 6);
            @(negedge clk);
            if (inst_valid_o) begin
                rel_at = i;
                chk("to_pulse", timeout_o, 1);
                break;
            end
            if (weight_wait_o) waits++;
            step(1);
        end
        enable_i = 1;
        chk("to_release_cycle", rel_at, 12);
        chk("to_wait_cycles", waits, TO);
        step(1);
        @(negedge clk);
        chk("to_pulse_end", timeout_o, 0);
        chk("to_count", count_o, 0);
        step(1);
`else
        waits  = 0;
        rel_at = 0;
`endif

        step(2);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
